// File: rtl/conv_dual_mac_if.sv
// Beat-in / window-result-out bundle between the window feeder, the dual MAC
// and the requant stage. No backpressure in either direction.
interface conv_dual_mac_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
);
    logic                     in_valid;
    logic                     in_last;
    logic                     in_mode;
    logic signed [DATA_W-1:0] data_a;
    logic signed [DATA_W-1:0] data_d;
    logic signed [DATA_W-1:0] data_b;
    logic                     acc_clr;
    logic                     out_valid;
    logic signed [ACC_W-1:0]  acc_ab;
    logic signed [ACC_W-1:0]  acc_db;
    logic                     ovf;

    // MAC side
    modport slave (
        input  in_valid, in_last, in_mode, data_a, data_d, data_b, acc_clr,
        output out_valid, acc_ab, acc_db, ovf
    );

    // feeder / consumer side
    modport master (
        output in_valid, in_last, in_mode, data_a, data_d, data_b, acc_clr,
        input  out_valid, acc_ab, acc_db, ovf
    );
endinterface

// File: rtl/conv_dual_mac.sv
// Packed dual MAC: two activations share one weight through a single wide
// multiply, products are split with borrow correction, then each lane
// accumulates over the kernel window. Four fixed stages:
//   S1 input regs, S2 packed multiply, S3 unpack, S4 accumulate/output.

// One accumulator lane: saturating or wrapping add plus sticky window overflow.
module conv_dual_mac_lane #(
    parameter int PW     = 16,
    parameter int ACC_W  = 24,
    parameter bit SAT_EN = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    vld_i,
    input  logic                    last_i,
    input  logic                    clr_i,
    input  logic signed [PW-1:0]    p_i,
    output logic signed [ACC_W-1:0] sum_o,
    output logic                    wovf_o
);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] acc_q, acc_d, base;
    logic             flag_q, flag_d, flag_base;
    logic [ACC_W:0]   sum_x;
    logic             ov;

    // Add the product to the (possibly cleared) running sum, detect and
    // optionally clamp signed overflow, and pick the next accumulator state.
    always_comb begin
        base      = clr_i ? '0 : acc_q;
        flag_base = clr_i ? 1'b0 : flag_q;
        sum_x     = {base[ACC_W-1], base} + {{(ACC_W+1-PW){p_i[PW-1]}}, p_i};
        ov        = sum_x[ACC_W] != sum_x[ACC_W-1];
        if (SAT_EN && ov)
            sum_o = sum_x[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            sum_o = sum_x[ACC_W-1:0];
        wovf_o = flag_base | ov;
        acc_d  = acc_q;
        flag_d = flag_q;
        if (vld_i) begin
            // a last beat hands its sum to the output and the next window starts at 0
            acc_d  = last_i ? '0 : sum_o;
            flag_d = last_i ? 1'b0 : wovf_o;
        end else if (clr_i) begin
            acc_d  = '0;
            flag_d = 1'b0;
        end
    end

    // Partial-window accumulator and overflow flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            flag_q <= flag_d;
        end
    end
endmodule

module conv_dual_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter bit SAT_EN = 1'b1
) (
    input  logic           sclk,
    input  logic           s_rst_n,
    conv_dual_mac_if.slave bus
);
    localparam int W  = DATA_W;
    localparam int PW = 2 * DATA_W;   // per-lane product width and packing shift
    localparam int KW = 3 * DATA_W + 1; // packed operand width
    localparam int MW = 4 * DATA_W + 1; // packed product width

    // valid/last shift registers; index k holds the beat leaving stage k
    logic [3:1] vld_pipe_q, last_pipe_q;

    logic          s1_mode_q;
    logic [W-1:0]  s1_a_q, s1_d_q, s1_b_q;

    logic          s2_mode_q, s2_anz_q, s2_dnz_q;
    logic [W-1:0]  s2_b_q;
    logic [MW-2:0] s2_p_q;

    // lane 0 = AB, lane 1 = DB
    logic [1:0][PW-1:0] s3_p_d, s3_p_q;

    logic [KW-1:0] pk;
    logic [MW-1:0] pk_x, b_x, prod;
    logic          unused_prod_msb;

    logic [1:0][ACC_W-1:0] lane_sum;
    logic [1:0]            lane_wovf;

    logic             out_valid_q, ovf_q;
    logic [ACC_W-1:0] acc_ab_q, acc_db_q;

    // Valid/last travel together; last is only meaningful with valid.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            vld_pipe_q  <= {vld_pipe_q[2:1], bus.in_valid};
            last_pipe_q <= {last_pipe_q[2:1], bus.in_valid & bus.in_last};
        end
    end

    // S1: register the beat.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            s1_mode_q <= 1'b0;
            s1_a_q    <= '0;
            s1_d_q    <= '0;
            s1_b_q    <= '0;
        end else begin
            s1_mode_q <= bus.in_mode;
            s1_a_q    <= bus.data_a;
            s1_d_q    <= bus.data_d;
            s1_b_q    <= bus.data_b;
        end
    end

    // S2 datapath: pk = (a << 2W) + d, product = pk * b, all sign-extended.
    always_comb begin
        pk   = {s1_a_q[W-1], s1_a_q, {PW{1'b0}}} + {{(PW+1){s1_d_q[W-1]}}, s1_d_q};
        pk_x = {{(MW-KW){pk[KW-1]}}, pk};
        b_x  = {{(MW-W){s1_b_q[W-1]}}, s1_b_q};
        prod = pk_x * b_x;
    end

    // top bit only carries sign of a*b*2^2W, which the unpack does not need
    assign unused_prod_msb = prod[MW-1];

    // S2: packed product plus what the spike path needs.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            s2_mode_q <= 1'b0;
            s2_anz_q  <= 1'b0;
            s2_dnz_q  <= 1'b0;
            s2_b_q    <= '0;
            s2_p_q    <= '0;
        end else begin
            s2_mode_q <= s1_mode_q;
            s2_anz_q  <= |s1_a_q;
            s2_dnz_q  <= |s1_d_q;
            s2_b_q    <= s1_b_q;
            s2_p_q    <= prod[MW-2:0];
        end
    end

    // S3 unpack: low half is d*b; high half is a*b minus one whenever d*b
    // was negative, so add the low half's sign bit back. Spike mode gates b.
    always_comb begin
        if (s2_mode_q) begin
            s3_p_d[0] = s2_anz_q ? {{(PW-W){s2_b_q[W-1]}}, s2_b_q} : '0;
            s3_p_d[1] = s2_dnz_q ? {{(PW-W){s2_b_q[W-1]}}, s2_b_q} : '0;
        end else begin
            s3_p_d[0] = s2_p_q[2*PW-1:PW] + {{(PW-1){1'b0}}, s2_p_q[PW-1]};
            s3_p_d[1] = s2_p_q[PW-1:0];
        end
    end

    // S3: per-lane products.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) s3_p_q <= '0;
        else          s3_p_q <= s3_p_d;
    end

    // S4: one accumulator per lane.
    for (genvar l = 0; l < 2; l++) begin : g_lane
        conv_dual_mac_lane #(
            .PW     (PW),
            .ACC_W  (ACC_W),
            .SAT_EN (SAT_EN)
        ) u_lane (
            .clk_i   (sclk),
            .rst_n_i (s_rst_n),
            .vld_i   (vld_pipe_q[3]),
            .last_i  (last_pipe_q[3]),
            .clr_i   (bus.acc_clr),
            .p_i     (s3_p_q[l]),
            .sum_o   (lane_sum[l]),
            .wovf_o  (lane_wovf[l])
        );
    end

    // S4 output: capture the window result on a last beat and hold it.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            out_valid_q <= 1'b0;
            acc_ab_q    <= '0;
            acc_db_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= vld_pipe_q[3] & last_pipe_q[3];
            if (vld_pipe_q[3] && last_pipe_q[3]) begin
                acc_ab_q <= lane_sum[0];
                acc_db_q <= lane_sum[1];
                ovf_q    <= |lane_wovf;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.acc_ab    = acc_ab_q;
    assign bus.acc_db    = acc_db_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_conv_dual_mac.sv
// Directed bench for conv_dual_mac: a 24-bit accumulator build and a 16-bit
// saturating build driven with identical beats.
module tb_conv_dual_mac;
    logic sclk    = 1'b0;
    logic s_rst_n = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   n_pulse = 0;

    conv_dual_mac_if #(.DATA_W(8), .ACC_W(24)) bus ();
    conv_dual_mac_if #(.DATA_W(8), .ACC_W(16)) bus16 ();

    conv_dual_mac #(.DATA_W(8), .ACC_W(24), .SAT_EN(1'b1)) dut (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .bus     (bus)
    );

    conv_dual_mac #(.DATA_W(8), .ACC_W(16), .SAT_EN(1'b1)) dut16 (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .bus     (bus16)
    );

    always #5 sclk = ~sclk;

    // count result pulses of the 24-bit build
    always @(negedge sclk) if (bus.out_valid === 1'b1) n_pulse <= n_pulse + 1;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int ab, input int db, input int ov);
        chk({tag, ".vld"}, bus.out_valid, 1);
        chk({tag, ".ab"},  $signed(bus.acc_ab), ab);
        chk({tag, ".db"},  $signed(bus.acc_db), db);
        chk({tag, ".ovf"}, bus.ovf, ov);
    endtask

    task automatic chk_out16(input string tag, input int ab, input int db, input int ov);
        chk({tag, ".vld"}, bus16.out_valid, 1);
        chk({tag, ".ab"},  $signed(bus16.acc_ab), ab);
        chk({tag, ".db"},  $signed(bus16.acc_db), db);
        chk({tag, ".ovf"}, bus16.ovf, ov);
    endtask

    task automatic drive(input logic last, input logic mode, input int a, input int d, input int b);
        bus.in_valid = 1'b1;  bus.in_last = last;  bus.in_mode = mode;  bus.acc_clr = 1'b0;
        bus.data_a = 8'(a);   bus.data_d = 8'(d);  bus.data_b = 8'(b);
        bus16.in_valid = 1'b1; bus16.in_last = last; bus16.in_mode = mode; bus16.acc_clr = 1'b0;
        bus16.data_a = 8'(a);  bus16.data_d = 8'(d); bus16.data_b = 8'(b);
        @(posedge sclk); #1;
    endtask

    task automatic idle(input logic clr);
        bus.in_valid = 1'b0;   bus.in_last = 1'b0;   bus.acc_clr = clr;
        bus16.in_valid = 1'b0; bus16.in_last = 1'b0; bus16.acc_clr = clr;
        @(posedge sclk); #1;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_mode = 1'b0; bus.acc_clr = 1'b0;
        bus.data_a = '0; bus.data_d = '0; bus.data_b = '0;
        bus16.in_valid = 1'b0; bus16.in_last = 1'b0; bus16.in_mode = 1'b0; bus16.acc_clr = 1'b0;
        bus16.data_a = '0; bus16.data_d = '0; bus16.data_b = '0;

        // reset state
        repeat (2) @(posedge sclk);
        #1;
        chk("rst.vld", bus.out_valid, 0);
        chk("rst.ab",  $signed(bus.acc_ab), 0);
        chk("rst.db",  $signed(bus.acc_db), 0);
        chk("rst.ovf", bus.ovf, 0);
        s_rst_n = 1'b1;
        idle(1'b0);

        // 1: single last beat, exact latency
        drive(1'b1, 1'b0, 3, -2, 5);
        idle(1'b0); idle(1'b0);
        chk("t1.early", bus.out_valid, 0);
        idle(1'b0);
        chk_out("t1", 15, -10, 0);
        idle(1'b0);
        chk("t1.pulse", bus.out_valid, 0);
        chk("t1.hold",  $signed(bus.acc_ab), 15);

        // 2: borrow corners, three back-to-back one-beat windows
        drive(1'b1, 1'b0, 1, -1, 1);
        drive(1'b1, 1'b0, -128, -128, -128);
        drive(1'b1, 1'b0, -128, 127, -128);
        idle(1'b0); chk_out("t2a", 1, -1, 0);
        idle(1'b0); chk_out("t2b", 16384, 16384, 0);
        idle(1'b0); chk_out("t2c", 16384, -16256, 0);
        idle(1'b0); chk("t2.pulse", bus.out_valid, 0);

        // 3: nine-beat window with bubbles, then a fresh window
        for (int i = 0; i < 9; i++) begin
            drive(i == 8, 1'b0, 127, 127, 127);
            if (i % 3 == 1) idle(1'b0);
        end
        idle(1'b0); idle(1'b0);
        chk("t3.early", bus.out_valid, 0);
        idle(1'b0);
        chk_out("t3", 145161, 145161, 0);
        chk_out16("t3s", 32767, 32767, 1);
        idle(1'b0);
        chk("t3.pulse", bus.out_valid, 0);
        drive(1'b1, 1'b0, 2, -3, 4);
        idle(1'b0); idle(1'b0); idle(1'b0);
        chk_out("t3n", 8, -12, 0);
        chk_out16("t3n16", 8, -12, 0);

        // 4: saturation in the 16-bit build, both signs, then a clean window
        drive(1'b0, 1'b0, 127, 127, 127);
        drive(1'b0, 1'b0, 127, 127, 127);
        drive(1'b1, 1'b0, 127, 127, 127);
        idle(1'b0); idle(1'b0); idle(1'b0);
        chk_out16("t4", 32767, 32767, 1);
        chk_out("t4w", 48387, 48387, 0);
        drive(1'b0, 1'b0, 127, -128, 127);
        drive(1'b0, 1'b0, 127, -128, 127);
        drive(1'b1, 1'b0, 127, -128, 127);
        idle(1'b0); idle(1'b0); idle(1'b0);
        chk_out16("t4n", 32767, -32768, 1);
        drive(1'b1, 1'b0, 1, 1, 1);
        idle(1'b0); idle(1'b0); idle(1'b0);
        chk_out16("t4c", 1, 1, 0);

        // 5: spike mode, then a mixed INT/spike window
        drive(1'b0, 1'b1, 0, 7, -4);
        drive(1'b1, 1'b1, 5, 0, 9);
        idle(1'b0); idle(1'b0); idle(1'b0);
        chk_out("t5", 9, -4, 0);
        drive(1'b0, 1'b0, 3, -2, 5);
        drive(1'b0, 1'b1, -1, 0, -6);
        drive(1'b1, 1'b0, -7, 4, -3);
        idle(1'b0); idle(1'b0); idle(1'b0);
        chk_out("t5m", 30, -22, 0);

        // 6: reset with beats in flight, then clear coincident with a last beat in S4
        drive(1'b0, 1'b0, 10, 10, 10);
        drive(1'b1, 1'b0, 10, 10, 10);
        s_rst_n = 1'b0;
        idle(1'b0);
        chk("t6.rst.vld", bus.out_valid, 0);
        chk("t6.rst.ab",  $signed(bus.acc_ab), 0);
        chk("t6.rst.db",  $signed(bus.acc_db), 0);
        chk("t6.rst.ovf", bus.ovf, 0);
        s_rst_n = 1'b1;
        repeat (5) idle(1'b0);
        chk("t6.stale", n_pulse, 11);
        drive(1'b1, 1'b0, 1, 2, 3);
        idle(1'b0); idle(1'b0); idle(1'b0);
        chk_out("t6a", 3, 6, 0);
        drive(1'b0, 1'b0, 4, 4, 4);
        drive(1'b1, 1'b0, 2, 3, -5);
        idle(1'b0); idle(1'b0);
        idle(1'b1);
        chk_out("t6clr", -10, -15, 0);
        idle(1'b0);
        chk("t6.pulse", bus.out_valid, 0);
        chk("pulses", n_pulse, 13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
